// File: rtl/cs_window_approx_pkg.sv
// Shared widths and helpers for the nine-sample approximate-mean window filter.
// The window sum and final accumulator widths are sized for all-255 input.
package cs_window_approx_pkg;

    localparam int WIN_LEN = 9;
    localparam int X_W     = 8;
    localparam int SUM_W   = 12;
    localparam int Y_W     = 10;
    localparam int ACC_W   = 13;

    function automatic logic [X_W-1:0] max_x(input logic [X_W-1:0] a,
                                              input logic [X_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cs_approx_sel.sv
// Picks the largest window sample not above the window mean: 9*W[i] <= S marks a
// candidate, non-candidates are masked to zero, then a balanced max tree reduces.
module cs_approx_sel
    import cs_window_approx_pkg::*;
(
    input  logic [X_W-1:0]   win_i [WIN_LEN],
    input  logic [SUM_W-1:0] sum_i,
    output logic [X_W-1:0]   xappr_o
);

    logic [SUM_W-1:0] nine_w [WIN_LEN];
    logic [X_W-1:0]   masked [WIN_LEN];
    logic [X_W-1:0]   lvl1   [4];
    logic [X_W-1:0]   lvl2   [2];
    logic [X_W-1:0]   lvl3;

    always_comb begin
        for (int i = 0; i < WIN_LEN; i++) begin
            nine_w[i] = ({{(SUM_W-X_W){1'b0}}, win_i[i]} << 3)
                      + {{(SUM_W-X_W){1'b0}}, win_i[i]};
            // Zero is a safe mask value: the window minimum always qualifies.
            masked[i] = (nine_w[i] <= sum_i) ? win_i[i] : '0;
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            lvl1[j] = max_x(masked[2*j], masked[2*j+1]);
        end
        lvl2[0] = max_x(lvl1[0], lvl1[1]);
        lvl2[1] = max_x(lvl1[2], lvl1[3]);
        lvl3    = max_x(lvl2[0], lvl2[1]);
        xappr_o = max_x(lvl3, masked[WIN_LEN-1]);
    end

endmodule

// File: rtl/cs_window_approx.sv
// Sliding nine-sample window with a running sum; Y = floor((S + 9*Xappr) / 8)
// is purely combinational from the registers, so there is no output pipeline stage.
module cs_window_approx
    import cs_window_approx_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] X,
    output logic [Y_W-1:0] Y
);

    logic [X_W-1:0]   window_q [WIN_LEN];
    logic [X_W-1:0]   window_d [WIN_LEN];
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [X_W-1:0]   xappr;
    logic [ACC_W-1:0] acc;

    always_comb begin
        window_d[0] = X;
        for (int i = 1; i < WIN_LEN; i++) begin
            window_d[i] = window_q[i-1];
        end
        // Modular 12-bit arithmetic keeps the running sum exact: the true sum always fits.
        sum_d = sum_q + {{(SUM_W-X_W){1'b0}}, X}
                      - {{(SUM_W-X_W){1'b0}}, window_q[WIN_LEN-1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                window_q[i] <= '0;
            end
            sum_q <= '0;
        end else begin
            for (int i = 0; i < WIN_LEN; i++) begin
                window_q[i] <= window_d[i];
            end
            sum_q <= sum_d;
        end
    end

    cs_approx_sel u_sel (
        .win_i   (window_q),
        .sum_i   (sum_q),
        .xappr_o (xappr)
    );

    always_comb begin
        acc = {{(ACC_W-SUM_W){1'b0}}, sum_q}
            + ({{(ACC_W-X_W){1'b0}}, xappr} << 3)
            + {{(ACC_W-X_W){1'b0}}, xappr};
        Y = Y_W'(acc >> 3);
    end

endmodule

// File: tb/tb_cs_window_approx.sv
// Directed and random stimulus for cs_window_approx, checked against an
// arithmetic model of the nine most recent samples.
module tb_cs_window_approx;

    logic       clk;
    logic       reset;
    logic [7:0] X;
    logic [9:0] Y;

    int n_checks = 0;
    int n_fail   = 0;
    int win [9];

    cs_window_approx dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_y();
        int s;
        int best;
        s = 0;
        best = 0;
        foreach (win[i]) s += win[i];
        foreach (win[i]) if (9 * win[i] <= s && win[i] > best) best = win[i];
        return (s + 9 * best) / 8;
    endfunction

    task automatic model_clear();
        foreach (win[i]) win[i] = 0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample (inputs change on falling edge), capture it, compare on next falling edge.
    task automatic push(input int x);
        X = 8'(x);
        @(posedge clk);
        for (int i = 8; i > 0; i--) win[i] = win[i-1];
        win[0] = x;
        @(negedge clk);
        check("model", int'(Y), model_y());
    endtask

    initial begin
        model_clear();
        X = 8'd0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_held", int'(Y), 0);
        reset = 1'b1;
        @(negedge clk);
        check("after_release", int'(Y), 0);

        for (int k = 0; k < 12; k++) push(100);
        check("const_100", int'(Y), 225);

        for (int k = 0; k < 9; k++) push(255);
        check("const_255", int'(Y), 573);

        for (int k = 0; k < 9; k++) push(k);
        check("ramp_0_8", int'(Y), 9);

        push(1); push(9);
        for (int k = 0; k < 7; k++) push(5);
        check("mean_equal", int'(Y), 11);

        for (int k = 0; k < 8; k++) push(1);
        push(10);
        check("ones_then_10", int'(Y), 3);

        // Mid-stream asynchronous reset, away from any clock edge.
        for (int k = 0; k < 5; k++) push($urandom_range(50, 255));
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", int'(Y), 0);
        model_clear();
        @(negedge clk);
        check("reset_hold2", int'(Y), 0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) push(100);
        check("refill_8", int'(Y), 100);
        push(100);
        check("refill_9", int'(Y), 225);

        for (int k = 0; k < 2000; k++) begin
            case ($urandom_range(0, 3))
                0:       push($urandom_range(0, 255));
                1:       push($urandom_range(0, 15));
                2:       push($urandom_range(240, 255));
                default: push($urandom_range(90, 110));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cs_window_approx.md
# cs_window_approx

Streaming filter over a sliding window of the nine most recent 8-bit samples. Each cycle it computes the window sum, picks the approximate value (the largest sample not exceeding the window mean), and drives Y = floor((sum + 9·Xappr) / 8). It sits in the sample datapath, consuming one new sample per clock.

## Interface
- No parameters. Window length 9 and widths are fixed.
- `clk`  in  1  — rising-edge clock; all state is updated on this edge.
- `reset`  in  1  — asynchronous, active-low reset. Asserting it (`reset`=0) clears all state immediately; release is synchronised to `clk` by the system.
- `X`  in  8  — unsigned input sample, one per cycle.
- `Y`  out  10  — unsigned filtered result.

## Operation
- Window: 9-entry shift register W[0..8] of 8-bit samples, with W[0] the newest. On each rising edge, `X` is shifted in as W[0] and W[8] is discarded.
- Sum S = ΣW[i]:
  - maximum value 2295, held in 12 bits;
  - may be kept as a running sum (S + X − W[8] on each edge) or recomputed each cycle;
  - must be exact either way.
- Mean condition without division: W[i] is a candidate if and only if 9·W[i] ≤ S. This is equivalent to W[i] ≤ S/9 for a real-valued mean.
- Xappr is the maximum of the candidates. At least one candidate always exists, because the minimum of the window is never above the mean. Duplicate values need no special handling.
- Y = (S + 9·Xappr) >> 3:
  - the intermediate result is 13 bits, maximum 4590;
  - the result fits in 10 bits, maximum 573;
  - the result is truncated (floor), not rounded.
- Y is a combinational function of the window registers, and of the sum register if one is used. It has no extra pipeline stage.
- Reset:
  - clears every window entry, and the sum register if present, to 0;
  - gives Xappr = 0 and Y = 0 while reset is held and immediately after;
  - mid-stream, discards all history, so the window refills from zeros.
- Before 9 samples have been captured, Y is computed over a window padded with the reset zeros. This result is deterministic but not meaningful to consumers.

## Timing
- `X` is stable around each rising edge; the testbench changes it on the falling edge.
- Latency: at rising edge k, before that edge's capture, Y reflects the samples captured at edges k−9 … k−1.
- The first meaningful Y is present at the edge following the 9th sample capture.
- After that, one new Y per cycle, indefinitely, with no handshake.
- Y must meet 0.5 ns setup and 0.5 ns hold relative to each rising `clk` edge at the 9.9 ns target period. This requires clock-to-Y change ≥ 0.5 ns and the combinational path ≤ period − 0.5 ns.
- The compare/max tree is the critical path; it may be restructured, but no cycle of latency may be added.

## Structure
- Shared package constants: `WIN_LEN`=9, `X_W`=8, `SUM_W`=12, `Y_W`=10.
- One natural sub-module, `cs_approx_sel`:
  - takes the 9 samples and S;
  - performs the 9 parallel comparisons 9·W[i] ≤ S (form 9·W as (W<<3)+W);
  - uses a masked max-reduction tree to output Xappr.
- The top level holds the window and sum registers and the final add/shift.

## Test plan
- Constant X=100 for 9+ cycles → Y=225 (0x0E1) every cycle once the window is full.
- Constant X=255 → Y=573 (0x23D), the width upper bound; no overflow.
- Samples 0,1,…,8 → S=36, Xappr=4, Y=9.
- Samples 1,9,5,5,5,5,5,5,5 (mean exactly 5) → the equality case is included, Xappr=5, Y=11. Samples 1×8 followed by 10 → Xappr=1, Y=3.
- Assert `reset`=0 asynchronously mid-stream → Y=0 immediately. After release, the window refills; with constant 100, Y reaches 225 exactly 9 captures later.
- Random 2000-sample stream vs. a reference model → Y matches every cycle from the 10th edge on, with no setup/hold violations on Y at the 0.5 ns window.
